up_regmap_bank: RTL and testbench
=================================

Name: up_regmap_bank

Overview:
- Parameterised register bank on the up_* register bus.
- Implements per-bit access types RO, RW, RW1C and RW1S, the same semantics the testbench register-map package models with acc_t.
- Sits directly downstream of the bench's SetField/GetField accesses: bus writes and reads land here, and hardware-facing values and pulses go out to the IP core.
- Gives each IP a uniform, verifiable register file instead of hand-coded up_* decoders.

Parameters:
- NUM_REGS, 8, number of 32-bit registers.
- ADDR_WIDTH, 14, width of up_waddr/up_raddr (word addresses).
- BASE_ADDR, 'h0000, word address of register 0.
- RW_MASK, {NUM_REGS{32'h0}}, packed per-register RW bit mask (reg i at [32*i+:32]).
- W1C_MASK, {NUM_REGS{32'h0}}, packed per-register RW1C bit mask.
- W1S_MASK, {NUM_REGS{32'h0}}, packed per-register RW1S bit mask.
- RESET_VALUE, {NUM_REGS{32'h0}}, packed reset value; applies to RW bits only.
- IRQ_MASK, {NUM_REGS{32'h0}}, W1C bits that contribute to irq.

Ports:
- up_clk  in  1  register clock.
- up_rstn  in  1  asynchronous active-low reset.
- up_wreq  in  1  write request, single-cycle strobe.
- up_waddr  in  ADDR_WIDTH  write word address.
- up_wdata  in  32  write data.
- up_wack  out  1  write acknowledge.
- up_rreq  in  1  read request, single-cycle strobe.
- up_raddr  in  ADDR_WIDTH  read word address.
- up_rdata  out  32  read data; valid only with up_rack, 0 otherwise.
- up_rack  out  1  read acknowledge.
- hw_ro_value  in  32*NUM_REGS  live values for RO bits.
- hw_set  in  32*NUM_REGS  per-bit sticky-set events for W1C bits.
- reg_value  out  32*NUM_REGS  current stored RW and W1C bits; 0 elsewhere.
- w1s_pulse  out  32*NUM_REGS  one-cycle pulses for RW1S bits.
- irq  out  1  OR of (W1C state & IRQ_MASK), registered.

Behaviour:
- Clock and reset: one clock, up_clk. Reset is asynchronous and active-low on up_rstn.
- Reset values:
  - up_wack, up_rack, up_rdata, w1s_pulse and irq are 0.
  - RW bits equal RESET_VALUE; W1C bits are 0.
  - Reset mid-transaction drops any pending ack.
- Bit classes:
  - Any bit in none of the three masks is RO.
  - Overlapping masks are an elaboration-time $fatal.
- Address decode:
  - idx = addr - BASE_ADDR; an access is in range iff 0 <= idx < NUM_REGS.
  - Out-of-range accesses produce no ack and leave up_rdata at 0, so bus OR-muxing stays safe.
- Write (request in cycle N, in range):
  - up_wack = 1 in cycle N+1 only.
  - RW bits take up_wdata at the N→N+1 edge.
  - W1C bits with wdata=1 clear.
  - RW1S bits with wdata=1 give w1s_pulse=1 in cycle N+1 only.
  - RO bits ignore writes.
- Read (request in cycle N, in range):
  - up_rack = 1 and up_rdata valid in cycle N+1.
  - Data is sampled from state as of edge N: RW and W1C stored bits, RO bits from hw_ro_value, RW1S bits read 0.
  - Rdata returns to 0 the cycle after rack.
- Simultaneous read and write to the same register in the same cycle: the read returns the pre-write value.
- W1C bits:
  - hw_set=1 sets the bit at the next edge.
  - If hw_set and a write-1 clear hit the same bit in the same cycle, set wins and the bit stays 1.
- irq: registered, so it follows W1C state with one cycle of latency.
- Back-to-back requests every cycle are supported with no throughput loss.
- Requests must not be held high; each asserted cycle is a new access.

Decomposition:
- RTL package up_regmap_pkg:
  - access encoding enum mirroring acc_t (RO, RW, RW1C, RW1S);
  - a function that derives a per-bit access type from the three masks;
  - the constant UP_DATA_WIDTH = 32.
- Sub-module up_regmap_cell:
  - one 32-bit register with its masks;
  - inputs: write-enable, wdata, hw_set, hw_ro_value;
  - outputs: value, readback, w1s_pulse.
- up_regmap_bank instantiates NUM_REGS cells in a generate loop and adds the decode, ack and rdata pipeline.

Test Plan:
- Reset with reg0 RESET_VALUE='hA5A5_0000, RW_MASK='hFFFF_0000, hw_ro_value[0]='h0000_1234 → read reg0 returns 'hA5A5_1234, rack exactly 1 cycle after rreq.
- Write 'hDEAD_BEEF to reg0 → wack 1 cycle later; reg_value[0]='hDEAD_0000; readback 'hDEAD_1234.
- reg1 W1C_MASK='h0000_00FF, IRQ_MASK='h1:
  - pulse hw_set[32]=1 → bit reads 1 and irq=1 one cycle after the bit sets;
  - write 'h1 → bit clears and irq=0;
  - hw_set together with write 'h1 in the same cycle → bit stays 1.
- reg2 W1S_MASK='h8000_0000; write 'h8000_0000 → w1s_pulse[95]=1 for exactly one cycle (N+1); read returns 0.
- BASE_ADDR='h10, NUM_REGS=8; access address 'h18 and 'h0F → no wack or rack, up_rdata stays 0, no state change.
- Back-to-back: write reg0 and read reg0 in the same cycle, then read reg0 the next cycle → first read returns the old value, second returns the new one; assert up_rstn low mid-sequence → acks drop immediately and all state returns to reset values.

Source files
------------

// File: rtl/up_regmap_pkg.sv
// Shared definitions for the up_* register bank.
// Contents:
//   UP_DATA_WIDTH - width of one register and of the up_* data buses.
//   acc_t         - per-bit access class (RO, RW, RW1C, RW1S).
//   bit_access    - returns the access class of one bit from its three mask bits.
//   class_mask    - expands the three masks of a register into the 32-bit mask
//                   of all bits belonging to one access class.
package up_regmap_pkg;

    localparam int UP_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ACC_RO   = 2'd0,
        ACC_RW   = 2'd1,
        ACC_RW1C = 2'd2,
        ACC_RW1S = 2'd3
    } acc_t;

    // A bit in none of the masks is read-only.
    function automatic acc_t bit_access(input logic rw, input logic w1c, input logic w1s);
        if (rw) begin
            return ACC_RW;
        end else if (w1c) begin
            return ACC_RW1C;
        end else if (w1s) begin
            return ACC_RW1S;
        end
        return ACC_RO;
    endfunction

    function automatic logic [UP_DATA_WIDTH-1:0] class_mask(
        input acc_t                     want,
        input logic [UP_DATA_WIDTH-1:0] rw,
        input logic [UP_DATA_WIDTH-1:0] w1c,
        input logic [UP_DATA_WIDTH-1:0] w1s
    );
        logic [UP_DATA_WIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < UP_DATA_WIDTH; b++) begin
            m[b] = (bit_access(rw[b], w1c[b], w1s[b]) == want);
        end
        return m;
    endfunction

endpackage

// File: rtl/up_regmap_cell.sv
// One 32-bit register of the bank with per-bit access classes.
// Ports:
//   clk, rst_n   - register clock, asynchronous active-low reset.
//   we           - write strobe for this register (already address-decoded).
//   wdata        - write data.
//   hw_set       - per-bit sticky-set events for RW1C bits.
//   hw_ro_value  - live values shown on read for RO bits.
//   value        - stored RW and RW1C bits, 0 elsewhere.
//   readback     - combinational read view of the current state.
//   w1s_pulse    - registered one-cycle pulses for RW1S bits written with 1.
module up_regmap_cell
    import up_regmap_pkg::*;
#(
    parameter logic [UP_DATA_WIDTH-1:0] RW_MASK     = '0,
    parameter logic [UP_DATA_WIDTH-1:0] W1C_MASK    = '0,
    parameter logic [UP_DATA_WIDTH-1:0] W1S_MASK    = '0,
    parameter logic [UP_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [UP_DATA_WIDTH-1:0] wdata,
    input  logic [UP_DATA_WIDTH-1:0] hw_set,
    input  logic [UP_DATA_WIDTH-1:0] hw_ro_value,
    output logic [UP_DATA_WIDTH-1:0] value,
    output logic [UP_DATA_WIDTH-1:0] readback,
    output logic [UP_DATA_WIDTH-1:0] w1s_pulse
);

    localparam logic [UP_DATA_WIDTH-1:0] M_RW  = class_mask(ACC_RW,   RW_MASK, W1C_MASK, W1S_MASK);
    localparam logic [UP_DATA_WIDTH-1:0] M_W1C = class_mask(ACC_RW1C, RW_MASK, W1C_MASK, W1S_MASK);
    localparam logic [UP_DATA_WIDTH-1:0] M_W1S = class_mask(ACC_RW1S, RW_MASK, W1C_MASK, W1S_MASK);
    localparam logic [UP_DATA_WIDTH-1:0] M_RO  = class_mask(ACC_RO,   RW_MASK, W1C_MASK, W1S_MASK);

    if (((RW_MASK & W1C_MASK) | (RW_MASK & W1S_MASK) | (W1C_MASK & W1S_MASK)) != '0) begin : g_overlap
        $fatal(1, "up_regmap_cell: access masks overlap");
    end

    logic [UP_DATA_WIDTH-1:0] stored;
    logic [UP_DATA_WIDTH-1:0] w1c_clr;

    assign w1c_clr = we ? (wdata & M_W1C) : '0;

    // State update: hw_set is OR-ed in after the clear so a coincident set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored    <= RESET_VALUE & M_RW;
            w1s_pulse <= '0;
        end else begin
            stored    <= ((we ? wdata : stored) & M_RW)
                       | (((stored & ~w1c_clr) | hw_set) & M_W1C);
            w1s_pulse <= we ? (wdata & M_W1S) : '0;
        end
    end

    // stored only ever holds RW and RW1C bits, so RW1S bits read back as 0.
    assign value    = stored;
    assign readback = stored | (hw_ro_value & M_RO);

endmodule

// File: rtl/up_regmap_bank.sv
// Parameterised register bank on the up_* register bus.
// Ports:
//   up_clk, up_rstn        - clock, asynchronous active-low reset.
//   up_wreq/waddr/wdata    - single-cycle write request; up_wack one cycle later.
//   up_rreq/raddr          - single-cycle read request; up_rack and up_rdata one
//                            cycle later, up_rdata is 0 whenever up_rack is low.
//   hw_ro_value            - live values for RO bits (reg i at [32*i+:32]).
//   hw_set                 - sticky-set events for RW1C bits.
//   reg_value              - stored RW and RW1C bits to the IP core.
//   w1s_pulse              - one-cycle pulses for RW1S bits.
//   irq                    - registered OR of RW1C state under IRQ_MASK.
// Out-of-range addresses are never acknowledged and keep up_rdata at 0.
module up_regmap_bank
    import up_regmap_pkg::*;
#(
    parameter int                                  NUM_REGS    = 8,
    parameter int                                  ADDR_WIDTH  = 14,
    parameter logic [ADDR_WIDTH-1:0]               BASE_ADDR   = 'h0000,
    parameter logic [UP_DATA_WIDTH*NUM_REGS-1:0]   RW_MASK     = {NUM_REGS{32'h0}},
    parameter logic [UP_DATA_WIDTH*NUM_REGS-1:0]   W1C_MASK    = {NUM_REGS{32'h0}},
    parameter logic [UP_DATA_WIDTH*NUM_REGS-1:0]   W1S_MASK    = {NUM_REGS{32'h0}},
    parameter logic [UP_DATA_WIDTH*NUM_REGS-1:0]   RESET_VALUE = {NUM_REGS{32'h0}},
    parameter logic [UP_DATA_WIDTH*NUM_REGS-1:0]   IRQ_MASK    = {NUM_REGS{32'h0}}
) (
    input  logic                                 up_clk,
    input  logic                                 up_rstn,
    input  logic                                 up_wreq,
    input  logic [ADDR_WIDTH-1:0]                up_waddr,
    input  logic [UP_DATA_WIDTH-1:0]             up_wdata,
    output logic                                 up_wack,
    input  logic                                 up_rreq,
    input  logic [ADDR_WIDTH-1:0]                up_raddr,
    output logic [UP_DATA_WIDTH-1:0]             up_rdata,
    output logic                                 up_rack,
    input  logic [UP_DATA_WIDTH*NUM_REGS-1:0]    hw_ro_value,
    input  logic [UP_DATA_WIDTH*NUM_REGS-1:0]    hw_set,
    output logic [UP_DATA_WIDTH*NUM_REGS-1:0]    reg_value,
    output logic [UP_DATA_WIDTH*NUM_REGS-1:0]    w1s_pulse,
    output logic                                 irq
);

    logic [ADDR_WIDTH-1:0]    w_off;
    logic [ADDR_WIDTH-1:0]    r_off;
    logic                     w_hit;
    logic                     r_hit;
    logic [UP_DATA_WIDTH-1:0] cell_rb [NUM_REGS];
    logic [UP_DATA_WIDTH-1:0] rd_mux;

    // Stage 0: address decode, relative to BASE_ADDR.
    assign w_off = up_waddr - BASE_ADDR;
    assign r_off = up_raddr - BASE_ADDR;
    assign w_hit = (up_waddr >= BASE_ADDR) && (w_off < ADDR_WIDTH'(NUM_REGS));
    assign r_hit = (up_raddr >= BASE_ADDR) && (r_off < ADDR_WIDTH'(NUM_REGS));

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        up_regmap_cell #(
            .RW_MASK     (RW_MASK    [UP_DATA_WIDTH*i +: UP_DATA_WIDTH]),
            .W1C_MASK    (W1C_MASK   [UP_DATA_WIDTH*i +: UP_DATA_WIDTH]),
            .W1S_MASK    (W1S_MASK   [UP_DATA_WIDTH*i +: UP_DATA_WIDTH]),
            .RESET_VALUE (RESET_VALUE[UP_DATA_WIDTH*i +: UP_DATA_WIDTH])
        ) u_cell (
            .clk         (up_clk),
            .rst_n       (up_rstn),
            .we          (up_wreq && w_hit && (w_off == ADDR_WIDTH'(i))),
            .wdata       (up_wdata),
            .hw_set      (hw_set     [UP_DATA_WIDTH*i +: UP_DATA_WIDTH]),
            .hw_ro_value (hw_ro_value[UP_DATA_WIDTH*i +: UP_DATA_WIDTH]),
            .value       (reg_value  [UP_DATA_WIDTH*i +: UP_DATA_WIDTH]),
            .readback    (cell_rb[i]),
            .w1s_pulse   (w1s_pulse  [UP_DATA_WIDTH*i +: UP_DATA_WIDTH])
        );
    end

    // Read mux sees pre-edge state, so a same-cycle write is not visible yet.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_off == ADDR_WIDTH'(i)) begin
                rd_mux = cell_rb[i];
            end
        end
    end

    // Stage 1: registered acks, read data and irq.
    logic                     wr_vld_p1;
    logic                     rd_vld_p1;
    logic [UP_DATA_WIDTH-1:0] rdata_p1;
    logic                     irq_p1;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            wr_vld_p1 <= 1'b0;
            rd_vld_p1 <= 1'b0;
            rdata_p1  <= '0;
            irq_p1    <= 1'b0;
        end else begin
            wr_vld_p1 <= up_wreq && w_hit;
            rd_vld_p1 <= up_rreq && r_hit;
            rdata_p1  <= (up_rreq && r_hit) ? rd_mux : '0;
            irq_p1    <= |(reg_value & W1C_MASK & IRQ_MASK);
        end
    end

    assign up_wack  = wr_vld_p1;
    assign up_rack  = rd_vld_p1;
    assign up_rdata = rdata_p1;
    assign irq      = irq_p1;

endmodule

// File: tb/tb_up_regmap_bank.sv
// Scoreboard bench for up_regmap_bank: stimulus pushes expected acks and read
// data into queues, a negedge monitor pops and compares whenever an ack shows.
module tb_up_regmap_bank;

    localparam int NR = 8;
    localparam int AW = 14;
    localparam int VW = 32 * NR;

    localparam logic [AW-1:0] BASE = 14'h10;
    localparam logic [VW-1:0] P_RW    = 256'hFFFF_0000;
    localparam logic [VW-1:0] P_RST   = 256'hA5A5_0000;
    localparam logic [VW-1:0] P_W1C   = 256'h0000_00FF << 32;
    localparam logic [VW-1:0] P_IRQ   = 256'h1 << 32;
    localparam logic [VW-1:0] P_W1S   = 256'h8000_0000 << 64;

    logic          up_clk = 1'b0;
    logic          up_rstn = 1'b0;
    logic          up_wreq = 1'b0;
    logic [AW-1:0] up_waddr = '0;
    logic [31:0]   up_wdata = '0;
    logic          up_wack;
    logic          up_rreq = 1'b0;
    logic [AW-1:0] up_raddr = '0;
    logic [31:0]   up_rdata;
    logic          up_rack;
    logic [VW-1:0] hw_ro_value = '0;
    logic [VW-1:0] hw_set = '0;
    logic [VW-1:0] reg_value;
    logic [VW-1:0] w1s_pulse;
    logic          irq;

    up_regmap_bank #(
        .NUM_REGS    (NR),
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (BASE),
        .RW_MASK     (P_RW),
        .W1C_MASK    (P_W1C),
        .W1S_MASK    (P_W1S),
        .RESET_VALUE (P_RST),
        .IRQ_MASK    (P_IRQ)
    ) dut (
        .up_clk      (up_clk),
        .up_rstn     (up_rstn),
        .up_wreq     (up_wreq),
        .up_waddr    (up_waddr),
        .up_wdata    (up_wdata),
        .up_wack     (up_wack),
        .up_rreq     (up_rreq),
        .up_raddr    (up_raddr),
        .up_rdata    (up_rdata),
        .up_rack     (up_rack),
        .hw_ro_value (hw_ro_value),
        .hw_set      (hw_set),
        .reg_value   (reg_value),
        .w1s_pulse   (w1s_pulse),
        .irq         (irq)
    );

    always #5 up_clk = ~up_clk;

    int cyc = 0;
    always @(posedge up_clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      wr_q[$];
    int      n_checks = 0;
    int      n_fail = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge up_clk) begin
        if (up_wack) begin
            if (wr_q.size() == 0) begin
                chk("wack_spurious", VW'(up_wack), '0);
            end else begin
                chk("wack_cycle", VW'(cyc), VW'(wr_q.pop_front()));
            end
        end
        if (up_rack) begin
            if (rd_q.size() == 0) begin
                chk("rack_spurious", VW'(up_rack), '0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk("rack_cycle", VW'(cyc), VW'(e.due));
                chk("rdata", VW'(up_rdata), VW'(e.data));
            end
        end else begin
            chk("rdata_idle", VW'(up_rdata), '0);
        end
    end

    // Drives one bus cycle (called at posedge+1) and returns at the next posedge+1.
    task automatic issue(input logic w, input logic [AW-1:0] wa, input logic [31:0] wd, input logic whit,
                         input logic r, input logic [AW-1:0] ra, input logic [31:0] rexp, input logic rhit);
        up_wreq  = w;
        up_waddr = wa;
        up_wdata = wd;
        up_rreq  = r;
        up_raddr = ra;
        if (w && whit) wr_q.push_back(cyc + 1);
        if (r && rhit) rd_q.push_back('{cyc + 1, rexp});
        @(posedge up_clk);
        #1;
        up_wreq = 1'b0;
        up_rreq = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        issue(1'b1, a, d, 1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp);
        issue(1'b0, '0, '0, 1'b0, 1'b1, a, exp, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge up_clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        hw_ro_value[31:0]  = 32'h0000_1234;
        hw_ro_value[63:32] = 32'h1200_0000;
        hw_ro_value[95:64] = 32'h8000_0055;

        // Reset state
        idle(3);
        chk("rst_wack", VW'(up_wack), '0);
        chk("rst_rack", VW'(up_rack), '0);
        chk("rst_rdata", VW'(up_rdata), '0);
        chk("rst_irq", VW'(irq), '0);
        chk("rst_w1s", w1s_pulse, '0);
        chk("rst_reg_value", reg_value, 256'hA5A5_0000);
        up_rstn = 1'b1;
        idle(1);

        // RW + RO mix on reg0
        rd(BASE + 0, 32'hA5A5_1234);
        idle(1);
        wr(BASE + 0, 32'hDEAD_BEEF);
        chk("reg0_after_write", reg_value, 256'hDEAD_0000);
        rd(BASE + 0, 32'hDEAD_1234);
        idle(1);

        // W1C on reg1 with irq
        hw_set[32] = 1'b1;
        idle(1);
        hw_set = '0;
        chk("w1c_set", VW'(reg_value[63:32]), VW'(32'h1));
        chk("irq_lag", VW'(irq), '0);
        idle(1);
        chk("irq_set", VW'(irq), VW'(1'b1));
        rd(BASE + 1, 32'h1200_0001);
        wr(BASE + 1, 32'h0000_0001);
        chk("w1c_clear", VW'(reg_value[63:32]), '0);
        chk("irq_clear_lag", VW'(irq), VW'(1'b1));
        idle(1);
        chk("irq_cleared", VW'(irq), '0);
        hw_set[63:32] = 32'h0000_0110;
        idle(1);
        hw_set = '0;
        chk("w1c_set_masked", VW'(reg_value[63:32]), VW'(32'h10));
        idle(1);
        chk("irq_mask", VW'(irq), '0);
        hw_set[32] = 1'b1;
        wr(BASE + 1, 32'h0000_0001);
        hw_set = '0;
        chk("w1c_set_wins", VW'(reg_value[63:32]), VW'(32'h11));
        idle(1);
        chk("irq_set_wins", VW'(irq), VW'(1'b1));

        // W1S on reg2
        wr(BASE + 2, 32'h8000_0000);
        chk("w1s_pulse_on", w1s_pulse, 256'h8000_0000 << 64);
        idle(1);
        chk("w1s_pulse_off", w1s_pulse, '0);
        chk("w1s_not_stored", VW'(reg_value[95:64]), '0);
        rd(BASE + 2, 32'h0000_0055);
        idle(1);

        // Out-of-range accesses: no acks, no state change
        issue(1'b1, 14'h18, 32'hFFFF_FFFF, 1'b0, 1'b1, 14'h0F, '0, 1'b0);
        issue(1'b1, 14'h0F, 32'hFFFF_FFFF, 1'b0, 1'b1, 14'h18, '0, 1'b0);
        idle(2);
        chk("oor_no_change", reg_value, (256'h11 << 32) | 256'hDEAD_0000);
        chk("oor_no_pulse", w1s_pulse, '0);

        // Back-to-back with same-cycle read/write
        issue(1'b1, BASE + 0, 32'h1357_9BDF, 1'b1, 1'b1, BASE + 0, 32'hDEAD_1234, 1'b1);
        rd(BASE + 0, 32'h1357_1234);

        // Reset while acks are showing
        issue(1'b1, BASE + 0, 32'hCAFE_F00D, 1'b1, 1'b1, BASE + 0, 32'h1357_1234, 1'b1);
        rd_q.delete();
        wr_q.delete();
        up_rstn = 1'b0;
        #1;
        chk("midrst_wack", VW'(up_wack), '0);
        chk("midrst_rack", VW'(up_rack), '0);
        chk("midrst_rdata", VW'(up_rdata), '0);
        chk("midrst_irq", VW'(irq), '0);
        chk("midrst_reg_value", reg_value, 256'hA5A5_0000);
        idle(2);
        up_rstn = 1'b1;
        idle(1);
        rd(BASE + 0, 32'hA5A5_1234);
        idle(3);

        chk("rd_q_drained", VW'(rd_q.size()), '0);
        chk("wr_q_drained", VW'(wr_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
